// File: rtl/hbridge_deadtime_driver.sv
// H-bridge gate driver with break-before-make dead time, overlap fault and turn-on counter.
// Optional sticky fault behaviour is enabled by defining HBRIDGE_FAULT_LATCH_EN.
module hbridge_deadtime_driver #(
    parameter int DT_WIDTH  = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 outp,
    input  logic                 outn,
    input  logic                 sysrun,
    input  logic                 bitout,
    input  logic [DT_WIDTH-1:0]  dead_time,
    output logic                 hs1,
    output logic                 ls1,
    output logic                 hs2,
    output logic                 ls2,
    output logic                 damp,
    output logic                 fault,
    output logic [CNT_WIDTH-1:0] on_cnt
);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DEAD = 2'd3
    } leg_state_t;

    leg_state_t          state     [2];
    leg_state_t          state_nxt [2];
    leg_state_t          target    [2];
    logic [DT_WIDTH-1:0] cnt       [2];
    logic [DT_WIDTH-1:0] cnt_nxt   [2];
    logic [1:0]          last;      // per leg: 1 = high side was conducting before DEAD
    logic [1:0]          last_nxt;
    logic [DT_WIDTH-1:0] dt_eff;
    logic                overlap;
    logic                block;
    logic                turn_on;
    logic                damp_q;

    assign dt_eff  = (dead_time == '0) ? DT_WIDTH'(1) : dead_time;
    assign overlap = outp & outn & sysrun;

`ifdef HBRIDGE_FAULT_LATCH_EN
    assign block = overlap | fault;
`else
    assign block = overlap;
`endif

    always_comb begin
        target[0] = OFF;
        target[1] = OFF;
        if (block) begin
            target[0] = OFF;
            target[1] = OFF;
        end else if (!sysrun) begin
            target[0] = LOW;
            target[1] = LOW;
        end else begin
            target[0] = outp ? HIGH : (outn ? LOW : OFF);
            target[1] = outn ? HIGH : (outp ? LOW : OFF);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            last_nxt[i]  = last[i];
            unique case (state[i])
                OFF: state_nxt[i] = target[i];
                HIGH: begin
                    if (target[i] != HIGH) begin
                        state_nxt[i] = DEAD;
                        cnt_nxt[i]   = dt_eff;
                        last_nxt[i]  = 1'b1;
                    end
                end
                LOW: begin
                    if (target[i] != LOW) begin
                        state_nxt[i] = DEAD;
                        cnt_nxt[i]   = dt_eff;
                        last_nxt[i]  = 1'b0;
                    end
                end
                DEAD: begin
                    // Returning to the FET that was just switched off cannot shoot through.
                    if (target[i] == (last[i] ? HIGH : LOW)) begin
                        state_nxt[i] = target[i];
                    end else if (cnt[i] == DT_WIDTH'(1)) begin
                        state_nxt[i] = target[i];
                    end else begin
                        cnt_nxt[i] = cnt[i] - DT_WIDTH'(1);
                    end
                end
            endcase
        end
    end

    // An aborted dead window back into HIGH is not a new turn-on.
    assign turn_on = (state_nxt[0] == HIGH) &&
                     ((state[0] == OFF) || ((state[0] == DEAD) && !last[0]));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                state[i] <= OFF;
                cnt[i]   <= '0;
            end
            last   <= '0;
            fault  <= 1'b0;
            damp_q <= 1'b0;
            on_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
            last   <= last_nxt;
`ifdef HBRIDGE_FAULT_LATCH_EN
            fault  <= fault | overlap;
`else
            fault  <= overlap;
`endif
            damp_q <= bitout;
            if (turn_on && (on_cnt != '1)) begin
                on_cnt <= on_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign hs1  = (state[0] == HIGH);
    assign ls1  = (state[0] == LOW);
    assign hs2  = (state[1] == HIGH);
    assign ls2  = (state[1] == LOW);
    assign damp = damp_q & ~fault;

endmodule
